pipelined_adder_tree: RTL and testbench

- Parametrised, fully pipelined reduction adder. Sums LEN N-bit operands per accepted beat.
- Optionally accumulates consecutive beats into one result, so the matrix datapath can form dot products longer than LEN.
- Sits between the multiplier array and the result writeback.
- Uses valid/ready handshakes on both sides with full-pipeline backpressure.

---
 rtl/pipelined_adder_tree_if.sv | 45 ++++
 rtl/pipelined_adder_tree.sv | 170 +++++++++++++++++
 tb/tb_pipelined_adder_tree.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_tree_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder_tree_if
// Description : Handshake bundle for pipelined_adder_tree. It carries the
//               operand-side valid/ready channel (with acc/last sideband bits)
//               and the result-side valid/ready channel.
//   in_valid  : beat present on in_data
//   in_ready  : block can accept a beat this cycle
//   in_data   : LEN operands of N bits, index 0..LEN-1
//   in_acc    : beat belongs to an accumulation group
//   in_last   : last beat of an accumulation group (ignored when in_acc=0)
//   out_valid : result present
//   out_ready : consumer accepts the result
//   out_data  : N-bit sum result
//   out_beats : number of beats summed into out_data
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_adder_tree_if #(
  parameter int N   = 32,
  parameter int LEN = 4,
  parameter int CW  = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data [LEN];
  logic           in_acc;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_data;
  logic [CW-1:0]  out_beats;

  // Producer / consumer side (drives operands, accepts results)
  modport master (
    output in_valid, in_data, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_beats
  );

  // Adder-tree side
  modport slave (
    input  in_valid, in_data, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_data, out_beats
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder_tree.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder_tree
// Description : Fully pipelined reduction adder. Each accepted beat of LEN
//               N-bit operands is summed through a registered binary tree of
//               depth ceil(log2 LEN), then an accumulate/output stage either
//               emits the beat sum directly or folds it into an open
//               accumulation group. All arithmetic wraps modulo 2^N.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of pipelined_adder_tree_if (both handshakes)
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder_tree #(
  parameter int N   = 32,
  parameter int LEN = 4,
  parameter int CW  = 16
) (
  input wire clk,
  input wire reset_n,
  pipelined_adder_tree_if.slave bus
);

  // Number of live nodes after k pairing levels.
  function automatic int lvl_width(input int k);
    int w;
    w = LEN;
    for (int i = 0; i < k; i++) w = (w + 1) / 2;
    return w;
  endfunction

  localparam int D = (LEN > 1) ? $clog2(LEN) : 0;

  // --------------------------------------------------------------------------
  // Global flow control: every stage moves together or holds together.
  // --------------------------------------------------------------------------
  logic r_out_valid;
  logic w_advance;

  assign w_advance   = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_advance;

  // --------------------------------------------------------------------------
  // Adder tree. Level 0 is the raw input beat; each later level is a register
  // stage holding ceil(previous/2) partial sums. Adjacent operands are paired
  // at every level; because addition modulo 2^N is associative and
  // commutative this yields the same depth and the same result as splitting
  // each node into its lower ceil(L/2) operands and the remainder.
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k <= D; k++) begin : g_lvl
      localparam int W = lvl_width(k);

      logic w_vld;
      logic w_acc;
      logic w_last;

      if (k == 0) begin : g_ctl_in
        assign w_vld  = bus.in_valid;
        assign w_acc  = bus.in_acc;
        assign w_last = bus.in_last;
      end else begin : g_ctl_reg
        logic r_vld;
        logic r_acc;
        logic r_last;

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_vld  <= 1'b0;
            r_acc  <= 1'b0;
            r_last <= 1'b0;
          end else if (w_advance) begin
            r_vld  <= g_lvl[k-1].w_vld;
            r_acc  <= g_lvl[k-1].w_acc;
            r_last <= g_lvl[k-1].w_last;
          end
        end

        assign w_vld  = r_vld;
        assign w_acc  = r_acc;
        assign w_last = r_last;
      end

      for (genvar j = 0; j < W; j++) begin : g_node
        logic [N-1:0] w_sum;

        if (k == 0) begin : g_leaf
          assign w_sum = bus.in_data[j];
        end else begin : g_add
          localparam int PW = lvl_width(k - 1);

          logic [N-1:0] r_sum;
          logic [N-1:0] w_nxt;

          if (2 * j + 1 < PW) begin : g_pair
            assign w_nxt = g_lvl[k-1].g_node[2*j].w_sum + g_lvl[k-1].g_node[2*j+1].w_sum;
          end else begin : g_pass
            // Odd node out at this level: forward it to keep stage alignment.
            assign w_nxt = g_lvl[k-1].g_node[2*j].w_sum;
          end

          always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
              r_sum <= '0;
            end else if (w_advance) begin
              r_sum <= w_nxt;
            end
          end

          assign w_sum = r_sum;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Accumulate / output stage
  // --------------------------------------------------------------------------
  logic [N-1:0]  w_tree_sum;
  logic          w_tree_vld;
  logic          w_tree_acc;
  logic          w_tree_last;

  assign w_tree_sum  = g_lvl[D].g_node[0].w_sum;
  assign w_tree_vld  = g_lvl[D].w_vld;
  assign w_tree_acc  = g_lvl[D].w_acc;
  assign w_tree_last = g_lvl[D].w_last;

  logic [N-1:0]  r_acc_sum;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_out_data;
  logic [CW-1:0] r_out_beats;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_beats <= '0;
      r_acc_sum   <= '0;
      r_cnt       <= '0;
    end else if (w_advance) begin
      // Default: a bubble or a non-final group beat produces no result. The
      // held out_data/out_beats are don't-care once valid drops.
      r_out_valid <= 1'b0;
      if (w_tree_vld) begin
        if (!w_tree_acc) begin
          // Standalone beat: bypasses, and leaves, any open group.
          r_out_valid <= 1'b1;
          r_out_data  <= w_tree_sum;
          r_out_beats <= CW'(1);
        end else if (!w_tree_last) begin
          r_acc_sum <= r_acc_sum + w_tree_sum;
          r_cnt     <= r_cnt + CW'(1);
        end else begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_acc_sum + w_tree_sum;
          r_out_beats <= r_cnt + CW'(1);
          r_acc_sum   <= '0;
          r_cnt       <= '0;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_beats = r_out_beats;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder_tree.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_adder_tree
// Description : Self-checking bench. A LEN=4 instance is driven with directed
//               beats and compared every cycle against a queue-based model of
//               the sum/accumulate rules; LEN=5 and LEN=1 instances cover the
//               odd and degenerate tree sizes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder_tree;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder_tree_if #(.N(32), .LEN(4), .CW(16)) bus4 ();
  pipelined_adder_tree_if #(.N(32), .LEN(5), .CW(16)) bus5 ();
  pipelined_adder_tree_if #(.N(32), .LEN(1), .CW(16)) bus1 ();

  pipelined_adder_tree #(.N(32), .LEN(4), .CW(16)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));
  pipelined_adder_tree #(.N(32), .LEN(5), .CW(16)) u_dut5 (.clk(clk), .reset_n(reset_n), .bus(bus5));
  pipelined_adder_tree #(.N(32), .LEN(1), .CW(16)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model for the LEN=4 instance: expected results queued at beat
  // acceptance, popped at result consumption.
  // --------------------------------------------------------------------------
  logic [31:0] exp_data_q[$];
  logic [15:0] exp_beats_q[$];
  logic [31:0] out_log[$];
  logic [31:0] m_acc;
  logic [15:0] m_cnt;
  int          n_out;
  int          stall_cycles;

  always @(negedge clk) begin
    logic [31:0] s;
    if (!reset_n) begin
      exp_data_q.delete();
      exp_beats_q.delete();
      m_acc = '0;
      m_cnt = '0;
    end else begin
      chk("in_ready_rule", bus4.in_ready, !bus4.out_valid || bus4.out_ready);
      if (!bus4.in_ready) stall_cycles++;
      if (bus4.out_valid && bus4.out_ready) begin
        n_out++;
        out_log.push_back(bus4.out_data);
        if (exp_data_q.size() == 0) begin
          chk("unexpected_result", 1'b1, 1'b0);
        end else begin
          chk("model_out_data", bus4.out_data, exp_data_q.pop_front());
          chk("model_out_beats", bus4.out_beats, exp_beats_q.pop_front());
        end
      end
      if (bus4.in_valid && bus4.in_ready) begin
        s = '0;
        for (int i = 0; i < 4; i++) s = s + bus4.in_data[i];
        if (!bus4.in_acc) begin
          exp_data_q.push_back(s);
          exp_beats_q.push_back(16'd1);
        end else if (!bus4.in_last) begin
          m_acc = m_acc + s;
          m_cnt = m_cnt + 16'd1;
        end else begin
          exp_data_q.push_back(m_acc + s);
          exp_beats_q.push_back(m_cnt + 16'd1);
          m_acc = '0;
          m_cnt = '0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic beat4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] d, input logic acc, input logic last, output int acyc);
    bit ok;
    int guard;
    bus4.in_data[0] = a;
    bus4.in_data[1] = b;
    bus4.in_data[2] = c;
    bus4.in_data[3] = d;
    bus4.in_acc     = acc;
    bus4.in_last    = last;
    bus4.in_valid   = 1'b1;
    ok    = 1'b0;
    guard = 0;
    acyc  = 0;
    while (!ok) begin
      @(negedge clk);
      ok   = bus4.in_ready;
      acyc = cyc;
      @(posedge clk);
      #1;
      guard++;
      if (!ok && guard > 50) begin
        chk("beat_accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    bus4.in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid; returns at the negedge where it is seen.
  task automatic wait_out4(output int ocyc, output bit seen);
    seen = 1'b0;
    ocyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus4.out_valid) begin
        seen = 1'b1;
        ocyc = cyc;
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  a, o, n0;
    bit  seen;
    n_tests = 0; n_fail = 0; cyc = 0; n_out = 0; stall_cycles = 0;
    reset_n = 1'b0;
    bus4.in_valid = 0; bus4.in_acc = 0; bus4.in_last = 0; bus4.out_ready = 1;
    for (int i = 0; i < 4; i++) bus4.in_data[i] = '0;
    bus5.in_valid = 0; bus5.in_acc = 0; bus5.in_last = 0; bus5.out_ready = 1;
    for (int i = 0; i < 5; i++) bus5.in_data[i] = '0;
    bus1.in_valid = 0; bus1.in_acc = 0; bus1.in_last = 0; bus1.out_ready = 1;
    bus1.in_data[0] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus4.out_valid, 1'b0);
    chk("rst_out_data", bus4.out_data, 32'd0);
    chk("rst_out_beats", bus4.out_beats, 16'd0);
    chk("rst_in_ready", bus4.in_ready, 1'b1);
    chk("rst_out_valid_len5", bus5.out_valid, 1'b0);
    chk("rst_out_valid_len1", bus1.out_valid, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: single beat, latency D+1 = 3
    beat4(1, 2, 3, 4, 1'b0, 1'b0, a);
    wait_out4(o, seen);
    chk("t1_seen", seen, 1'b1);
    chk("t1_latency", o - a, 3);
    chk("t1_data", bus4.out_data, 32'd10);
    chk("t1_beats", bus4.out_beats, 16'd1);
    @(posedge clk); #1;

    // 2: overflow standalone inside an open group; the group resumes after
    beat4(1, 1, 1, 1, 1'b1, 1'b0, a);
    beat4(32'hFFFF_FFFF, 1, 0, 0, 1'b0, 1'b0, a);
    wait_out4(o, seen);
    chk("t2_seen", seen, 1'b1);
    chk("t2_wrap_data", bus4.out_data, 32'h0000_0000);
    chk("t2_wrap_beats", bus4.out_beats, 16'd1);
    @(posedge clk); #1;
    beat4(1, 0, 0, 0, 1'b1, 1'b1, a);
    wait_out4(o, seen);
    chk("t2_group_data", bus4.out_data, 32'd5);
    chk("t2_group_beats", bus4.out_beats, 16'd2);
    @(posedge clk); #1;

    // 3: three-beat accumulation, exactly one result
    repeat (3) @(posedge clk); #1;
    n0 = n_out;
    beat4(1, 1, 1, 1, 1'b1, 1'b0, a);
    beat4(2, 2, 2, 2, 1'b1, 1'b0, a);
    beat4(3, 3, 3, 3, 1'b1, 1'b1, a);
    wait_out4(o, seen);
    chk("t3_seen", seen, 1'b1);
    chk("t3_latency", o - a, 3);
    chk("t3_data", bus4.out_data, 32'd24);
    chk("t3_beats", bus4.out_beats, 16'd3);
    repeat (4) @(posedge clk); #1;
    chk("t3_one_result", n_out - n0, 1);

    // 4: backpressure on 8 standalone beats with sums 1..8
    out_log.delete();
    stall_cycles = 0;
    fork
      begin
        for (int k = 1; k <= 8; k++) beat4(k, 0, 0, 0, 1'b0, 1'b0, a);
      end
      begin
        for (int c = 0; c < 20; c++) begin
          bus4.out_ready = !(c >= 4 && c <= 9);
          @(posedge clk); #1;
        end
        bus4.out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk); #1;
    chk("t4_count", out_log.size(), 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) chk("t4_order", out_log[i], i + 1);
    chk("t4_stalled", stall_cycles > 0, 1'b1);

    // 5: reset in the middle of an open group
    beat4(1, 1, 1, 1, 1'b1, 1'b0, a);
    beat4(1, 1, 1, 1, 1'b1, 1'b0, a);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_out_valid", bus4.out_valid, 1'b0);
    chk("t5_rst_out_data", bus4.out_data, 32'd0);
    chk("t5_rst_out_beats", bus4.out_beats, 16'd0);
    chk("t5_rst_in_ready", bus4.in_ready, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    beat4(5, 0, 0, 0, 1'b1, 1'b1, a);
    wait_out4(o, seen);
    chk("t5_seen", seen, 1'b1);
    chk("t5_data", bus4.out_data, 32'd5);
    chk("t5_beats", bus4.out_beats, 16'd1);
    @(posedge clk); #1;

    // 6a: LEN=5, latency 4
    bus5.in_data = '{1, 2, 3, 4, 5};
    bus5.in_valid = 1'b1;
    @(negedge clk);
    chk("t6_len5_ready", bus5.in_ready, 1'b1);
    a = cyc;
    @(posedge clk); #1;
    bus5.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus5.out_valid) begin seen = 1'b1; o = cyc; end
    end
    chk("t6_len5_seen", seen, 1'b1);
    chk("t6_len5_latency", o - a, 4);
    chk("t6_len5_data", bus5.out_data, 32'd15);
    chk("t6_len5_beats", bus5.out_beats, 16'd1);
    @(posedge clk); #1;

    // 6b: LEN=1, latency 1
    bus1.in_data[0] = 32'd7;
    bus1.in_valid = 1'b1;
    @(negedge clk);
    chk("t6_len1_ready", bus1.in_ready, 1'b1);
    a = cyc;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus1.out_valid) begin seen = 1'b1; o = cyc; end
    end
    chk("t6_len1_seen", seen, 1'b1);
    chk("t6_len1_latency", o - a, 1);
    chk("t6_len1_data", bus1.out_data, 32'd7);
    chk("t6_len1_beats", bus1.out_beats, 16'd1);

    repeat (6) @(posedge clk); #1;
    chk("model_drained", exp_data_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
